// File: rtl/hazard_pkg.sv
// Shared definitions for the multi-cycle hazard controller.
//   FWD_*    : EX operand forward-select encodings
//   mc_state_t: multi-cycle sequencer states
//   REG_ZERO : architectural zero register number (never forwarded)
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int REG_ZERO = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_mc_sat_counter.sv
// Saturating up-counter used for pipeline performance events.
//   clk      : clock
//   RegReset : synchronous active-high clear
//   inc      : count one event on this edge
//   count    : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         RegReset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (RegReset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard unit for the IF/ID/EX/MEM/WB pipeline with a multi-cycle EX
// sequencer, selectable branch-resolution stage and event counters.
//   Inputs : stage register numbers / control bits, BranchD, PCSrcD/E,
//            MultiCycleE, clk, RegReset (sync, active-high)
//   Outputs: StallF/D/E, FlushD/E/M, ForwardAE/BE (2b), ForwardAD/BD,
//            McBusy (registered), StallCount/FlushCount (saturating)
//
// state | meaning
// IDLE  | no multi-cycle op in progress; a new one stalls and loads cnt
// BUSY  | op in progress; stall while cnt != 0, release when cnt == 0
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int BR_IN_D = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              RegReset,
  input  logic              BranchD,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MultiCycleE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              McBusy,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam logic [REG_AW-1:0] RZ      = REG_AW'(REG_ZERO);
  localparam logic [7:0]        CNT_INI = 8'(MC_LAT - 2);

  mc_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mc_busy_q, mc_busy_d;
  logic       mcstall, lwstall, brstall;

  always_comb begin
    ForwardAE = FWD_RF;
    if (RsE != RZ && RegWriteM && WriteRegM == RsE)      ForwardAE = FWD_MEM;
    else if (RsE != RZ && RegWriteW && WriteRegW == RsE) ForwardAE = FWD_WB;
    ForwardBE = FWD_RF;
    if (RtE != RZ && RegWriteM && WriteRegM == RtE)      ForwardBE = FWD_MEM;
    else if (RtE != RZ && RegWriteW && WriteRegW == RtE) ForwardBE = FWD_WB;
  end

  assign ForwardAD = (BR_IN_D != 0) && (RsD != RZ) && RegWriteM && (WriteRegM == RsD);
  assign ForwardBD = (BR_IN_D != 0) && (RtD != RZ) && RegWriteM && (WriteRegM == RtD);

  assign lwstall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
  assign brstall = (BR_IN_D != 0) && BranchD &&
                   ((RegWriteE && (WriteRegE != RZ) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                    (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));

  always_ff @(posedge clk) begin
    if (RegReset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mc_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mc_busy_q <= mc_busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcstall = 1'b0;
    case (state_q)
      IDLE: begin
        if (MultiCycleE && (MC_LAT > 1)) begin
          mcstall = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_INI;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          mcstall = 1'b1;
          cnt_d   = cnt_q - 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Busy flags the cycles spent stalling inside BUSY, so the release
    // cycle (cnt == 0) already reads 0.
    mc_busy_d = (state_d == BUSY) && (cnt_d != '0);
  end

  assign McBusy = mc_busy_q;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (mcstall) begin
      // EX holds its op; a bubble goes into MEM instead of EX.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (lwstall || brstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
    if (BR_IN_D != 0) begin
      FlushD = PCSrcD && !StallD;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk      (clk),
    .RegReset (RegReset),
    .inc      (StallF),
    .count    (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk      (clk),
    .RegReset (RegReset),
    .inc      (FlushD | FlushE | FlushM),
    .count    (FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Three instances share the input stimulus:
//   a: defaults (MC_LAT=4, BR_IN_D=1, CNT_W=16)
//   b: MC_LAT=1
//   c: BR_IN_D=0, MC_LAT=8, CNT_W=2
module tb_hazard_ctrl_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RegReset, BranchD, PCSrcD, PCSrcE;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, MemtoRegE, MultiCycleE, RegWriteM, MemtoRegM, RegWriteW;

  logic        a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_fad, a_fbd, a_busy;
  logic [1:0]  a_fae, a_fbe;
  logic [15:0] a_sc, a_fc;
  logic        b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_fad, b_fbd, b_busy;
  logic [1:0]  b_fae, b_fbe;
  logic [15:0] b_sc, b_fc;
  logic        c_sf, c_sd, c_se, c_fd, c_fe, c_fm, c_fad, c_fbd, c_busy;
  logic [1:0]  c_fae, c_fbe;
  logic [1:0]  c_sc, c_fc;

  int total = 0;
  int bad   = 0;

  hazard_ctrl_mc dut_a (
    .clk(clk), .RegReset(RegReset), .BranchD(BranchD), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MultiCycleE(MultiCycleE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .FlushD(a_fd), .FlushE(a_fe), .FlushM(a_fm),
    .ForwardAE(a_fae), .ForwardBE(a_fbe), .ForwardAD(a_fad), .ForwardBD(a_fbd),
    .McBusy(a_busy), .StallCount(a_sc), .FlushCount(a_fc)
  );

  hazard_ctrl_mc #(.MC_LAT(1)) dut_b (
    .clk(clk), .RegReset(RegReset), .BranchD(BranchD), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MultiCycleE(MultiCycleE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .FlushD(b_fd), .FlushE(b_fe), .FlushM(b_fm),
    .ForwardAE(b_fae), .ForwardBE(b_fbe), .ForwardAD(b_fad), .ForwardBD(b_fbd),
    .McBusy(b_busy), .StallCount(b_sc), .FlushCount(b_fc)
  );

  hazard_ctrl_mc #(.BR_IN_D(0), .MC_LAT(8), .CNT_W(2)) dut_c (
    .clk(clk), .RegReset(RegReset), .BranchD(BranchD), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MultiCycleE(MultiCycleE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .StallF(c_sf), .StallD(c_sd), .StallE(c_se), .FlushD(c_fd), .FlushE(c_fe), .FlushM(c_fm),
    .ForwardAE(c_fae), .ForwardBE(c_fbe), .ForwardAD(c_fad), .ForwardBD(c_fbd),
    .McBusy(c_busy), .StallCount(c_sc), .FlushCount(c_fc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    BranchD = 0; PCSrcD = 0; PCSrcE = 0;
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; MemtoRegE = 0; MultiCycleE = 0;
    RegWriteM = 0; MemtoRegM = 0; RegWriteW = 0;
  endtask

  task automatic do_reset();
    RegReset = 1;
    clear_inputs();
    step();
    step();
    RegReset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({a_sf, a_sd, a_se, a_fd, a_fe, a_fm} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000", {a_sf, a_sd, a_se, a_fd, a_fe, a_fm});
    end
    total++;
    if ({a_sc, a_fc} !== 32'd0 || a_busy !== 1'b0) begin
      bad++; $display("FAIL reset_regs got sc=%0d fc=%0d busy=%b want 0 0 0", a_sc, a_fc, a_busy);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5; RtE = 5;
    #1;
    total++;
    if (a_fae !== 2'b10 || a_fbe !== 2'b10) begin
      bad++; $display("FAIL fwd_mem got A=%b B=%b want 10", a_fae, a_fbe);
    end
    RegWriteM = 0;
    #1;
    total++;
    if (a_fae !== 2'b01 || a_fbe !== 2'b01) begin
      bad++; $display("FAIL fwd_wb got A=%b B=%b want 01", a_fae, a_fbe);
    end
    RegWriteM = 1; RtE = 7;
    #1;
    total++;
    if (a_fae !== 2'b10 || a_fbe !== 2'b00) begin
      bad++; $display("FAIL fwd_mixed got A=%b B=%b want 10/00", a_fae, a_fbe);
    end
    RsE = 0; RtE = 0; WriteRegM = 0; WriteRegW = 0;
    #1;
    total++;
    if (a_fae !== 2'b00 || a_fbe !== 2'b00) begin
      bad++; $display("FAIL fwd_zero got A=%b B=%b want 00", a_fae, a_fbe);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    MemtoRegE = 1; RtE = 8; RsD = 8;
    #1;
    total++;
    if ({a_sf, a_sd, a_se, a_fe, a_fm} !== 5'b11010) begin
      bad++; $display("FAIL lw_stall got=%b want=11010", {a_sf, a_sd, a_se, a_fe, a_fm});
    end
    total++;
    if ({c_sf, c_sd, c_fe} !== 3'b111) begin
      bad++; $display("FAIL lw_stall_c got=%b want=111", {c_sf, c_sd, c_fe});
    end
    step();
    clear_inputs();
    #1;
    total++;
    if (a_sf !== 1'b0 || a_fe !== 1'b0) begin
      bad++; $display("FAIL lw_release got sf=%b fe=%b want 0 0", a_sf, a_fe);
    end
    total++;
    if (a_sc !== 16'd1 || a_fc !== 16'd1) begin
      bad++; $display("FAIL lw_counts got sc=%0d fc=%0d want 1 1", a_sc, a_fc);
    end
  endtask

  task automatic test_multicycle();
    logic exp_s, exp_b;
    do_reset();
    MultiCycleE = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_s = (i < 3);
      exp_b = (i == 1) || (i == 2);
      total++;
      if ({a_sf, a_sd, a_se, a_fm, a_fe} !== {exp_s, exp_s, exp_s, exp_s, 1'b0}) begin
        bad++; $display("FAIL mc_stall cyc=%0d got=%b want=%b", i,
                        {a_sf, a_sd, a_se, a_fm, a_fe}, {exp_s, exp_s, exp_s, exp_s, 1'b0});
      end
      total++;
      if (a_busy !== exp_b) begin
        bad++; $display("FAIL mc_busy cyc=%0d got=%b want=%b", i, a_busy, exp_b);
      end
      total++;
      if ({b_sf, b_se, b_fm, b_busy} !== 4'b0) begin
        bad++; $display("FAIL mc_lat1 cyc=%0d got=%b want=0000", i, {b_sf, b_se, b_fm, b_busy});
      end
      step();
    end
    MultiCycleE = 0;
    #1;
    total++;
    if (a_sc !== 16'd3 || a_fc !== 16'd3 || a_sf !== 1'b0) begin
      bad++; $display("FAIL mc_counts got sc=%0d fc=%0d sf=%b want 3 3 0", a_sc, a_fc, a_sf);
    end
    total++;
    if (b_sc !== 16'd0) begin
      bad++; $display("FAIL mc_lat1_count got=%0d want=0", b_sc);
    end
  endtask

  task automatic test_mc_load_use();
    logic exp_mc;
    do_reset();
    MultiCycleE = 1; MemtoRegE = 1; RtE = 8; RsD = 8;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_mc = (i < 3);
      total++;
      if ({a_sf, a_sd, a_se, a_fe, a_fm} !== {1'b1, 1'b1, exp_mc, !exp_mc, exp_mc}) begin
        bad++; $display("FAIL mc_lw cyc=%0d got=%b want=%b", i,
                        {a_sf, a_sd, a_se, a_fe, a_fm}, {1'b1, 1'b1, exp_mc, !exp_mc, exp_mc});
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_branch_d();
    do_reset();
    BranchD = 1; RegWriteE = 1; WriteRegE = 3; RsD = 3;
    #1;
    total++;
    if ({a_sf, a_sd, a_fe, a_fad} !== 4'b1110) begin
      bad++; $display("FAIL br_stall got=%b want=1110", {a_sf, a_sd, a_fe, a_fad});
    end
    total++;
    if (c_sf !== 1'b0) begin
      bad++; $display("FAIL br_stall_ex got=%b want=0", c_sf);
    end
    step();
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3;
    #1;
    total++;
    if ({a_fad, a_fbd, a_sf} !== 3'b100) begin
      bad++; $display("FAIL br_fwd got=%b want=100", {a_fad, a_fbd, a_sf});
    end
    PCSrcD = 1;
    #1;
    total++;
    if (a_fd !== 1'b1 || c_fd !== 1'b0) begin
      bad++; $display("FAIL br_flushd got a=%b c=%b want 1 0", a_fd, c_fd);
    end
    MemtoRegM = 1;
    #1;
    total++;
    if ({a_sd, a_fd} !== 2'b10) begin
      bad++; $display("FAIL br_flush_stalled got=%b want=10", {a_sd, a_fd});
    end
    clear_inputs();
  endtask

  task automatic test_branch_e();
    do_reset();
    PCSrcE = 1; RegWriteM = 1; WriteRegM = 3; RsD = 3;
    #1;
    total++;
    if ({c_fd, c_fe, c_fad} !== 3'b110) begin
      bad++; $display("FAIL bre_flush got=%b want=110", {c_fd, c_fe, c_fad});
    end
    total++;
    if ({a_fd, a_fe, a_fad} !== 3'b001) begin
      bad++; $display("FAIL bre_ignored_a got=%b want=001", {a_fd, a_fe, a_fad});
    end
    MemtoRegE = 1; RtE = 3;
    #1;
    total++;
    if ({c_sf, c_sd, c_fd, c_fe} !== 4'b1111) begin
      bad++; $display("FAIL bre_with_lw got=%b want=1111", {c_sf, c_sd, c_fd, c_fe});
    end
    clear_inputs();
  endtask

  task automatic test_reset_busy();
    do_reset();
    MultiCycleE = 1;
    step();
    step();
    total++;
    if (c_busy !== 1'b1 || c_sc !== 2'd2) begin
      bad++; $display("FAIL busy_pre got busy=%b sc=%0d want 1 2", c_busy, c_sc);
    end
    RegReset = 1; MultiCycleE = 0;
    step();
    RegReset = 0;
    #1;
    total++;
    if ({c_busy, c_sf, c_se} !== 3'b000 || c_sc !== 2'd0 || c_fc !== 2'd0) begin
      bad++; $display("FAIL busy_reset got busy/sf/se=%b sc=%0d fc=%0d want 000 0 0",
                      {c_busy, c_sf, c_se}, c_sc, c_fc);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    MemtoRegE = 1; RtE = 9; RtD = 9;
    repeat (5) step();
    clear_inputs();
    #1;
    total++;
    if (c_sc !== 2'd3 || c_fc !== 2'd3) begin
      bad++; $display("FAIL sat_c got sc=%0d fc=%0d want 3 3", c_sc, c_fc);
    end
    total++;
    if (a_sc !== 16'd5) begin
      bad++; $display("FAIL sat_a got sc=%0d want 5", a_sc);
    end
  endtask

  initial begin
    RegReset = 1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_mc_load_use();
    test_branch_d();
    test_branch_e();
    test_reset_busy();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Parametrised successor to the 5-stage pipeline's hazard unit.
- Generates stall, flush and forwarding controls for the IF/ID/EX/MEM/WB pipeline.
- Adds a multi-cycle EX operation sequencer (MUL/DIV style), selectable branch-resolution stage, and saturating stall/flush performance counters.
- Sits beside the stage modules in the pipelined top and replaces the fixed-function hazard unit.

Parameters:
- REG_AW, 5: register address width.
- MC_LAT, 4: total EX occupancy, in cycles, of a multi-cycle op; legal range 1..255.
- BR_IN_D, 1: 1 = branch resolved in decode (D-stage forwarding active); 0 = branch resolved in EX.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  clock
- RegReset  in  1  synchronous active-high reset
- BranchD  in  1  decode-stage instruction is a branch
- PCSrcD  in  1  branch taken, resolved in D (used only when BR_IN_D=1)
- PCSrcE  in  1  branch taken, resolved in E (used only when BR_IN_D=0)
- RsD, RtD  in  REG_AW  decode source registers
- RsE, RtE  in  REG_AW  execute source registers
- WriteRegE  in  REG_AW  execute destination
- RegWriteE, MemtoRegE  in  1  execute control bits
- MultiCycleE  in  1  EX instruction is a multi-cycle op
- WriteRegM  in  REG_AW; RegWriteM, MemtoRegM  in  1  memory stage
- WriteRegW  in  REG_AW; RegWriteW  in  1  writeback stage
- StallF, StallD, StallE  out  1  hold PC, IF/ID, ID/EX
- FlushD, FlushE, FlushM  out  1  clear IF/ID, ID/EX, EX/MEM
- ForwardAE, ForwardBE  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
- ForwardAD, ForwardBD  out  1  D-stage comparator forward from MEM
- McBusy  out  1  multi-cycle FSM in BUSY
- StallCount, FlushCount  out  CNT_W  saturating event counters

Behaviour:
- All control outputs are combinational from inputs plus FSM state. McBusy and the counters are registered.
- Reset:
  - While RegReset=1 at a clk edge: FSM goes to IDLE, count register to 0, StallCount=FlushCount=0, McBusy=0.
  - Reset mid-BUSY abandons the op; no stall is asserted the next cycle unless the inputs demand it.
- Forwarding, EX operand A (B identical with RtE):
  - ForwardAE=10 if RsE!=0 && RegWriteM && WriteRegM==RsE.
  - Else 01 if RsE!=0 && RegWriteW && WriteRegW==RsE.
  - Else 00. MEM has priority over WB.
- Forwarding, D stage (BR_IN_D=1):
  - ForwardAD = RsD!=0 && RegWriteM && WriteRegM==RsD; ForwardBD likewise with RtD.
  - Both are tied to 0 when BR_IN_D=0.
- lwstall = MemtoRegE && (RtE==RsD || RtE==RtD).
- brstall (BR_IN_D=1 only):
  - brstall = BranchD && ((RegWriteE && WriteRegE!=0 && (WriteRegE==RsD || WriteRegE==RtD)) || (MemtoRegM && (WriteRegM==RsD || WriteRegM==RtD))).
  - brstall = 0 when BR_IN_D=0.
- Multi-cycle FSM, states IDLE and BUSY, 8-bit count register cnt:
  - IDLE, MultiCycleE=1 and MC_LAT>1: mcstall=1; next state BUSY with cnt=MC_LAT-2.
  - BUSY, cnt!=0: mcstall=1; cnt decrements.
  - BUSY, cnt==0: mcstall=0; next state IDLE. E advances on this edge.
  - Result: MC_LAT-1 stall cycles. MC_LAT=1 never leaves IDLE.
- Priority:
  - mcstall: StallF=StallD=StallE=1, FlushM=1 (bubble into MEM), FlushE=0. The pending lwstall/brstall is deferred.
  - Else lwstall|brstall: StallF=StallD=1, FlushE=1.
  - Else all stalls 0.
- EX operand capture: the EX multi-cycle unit must latch its operands on the IDLE→BUSY cycle. Forward selects are not held constant during BUSY.
- Branch flush:
  - BR_IN_D=1: FlushD = PCSrcD && !StallD.
  - BR_IN_D=0: PCSrcE → FlushD=1 and FlushE=1. PCSrcE overrides a coincident lwstall flush, i.e. FlushE stays 1.
- Counters:
  - StallCount increments on every clk edge with StallF=1.
  - FlushCount increments on every edge with FlushD|FlushE|FlushM.
  - Both saturate at all-ones and never wrap.

Decomposition:
- Package hazard_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - mc_state_t enum {IDLE, BUSY}.
  - REG_ZERO constant.
- One natural sub-module: sat_counter, parameter W, inputs clk/RegReset/inc, output count; instanced twice.

Test Plan:
- Forwarding priority: RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RsE=5 → ForwardAE=10. Drop RegWriteM → 01. Set all register numbers to 0 → 00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 for one cycle → StallF=StallD=FlushE=1 for exactly that cycle; StallCount 0→1, FlushCount 0→1.
- Multi-cycle, MC_LAT=4: MultiCycleE=1 from cycle 0 → StallF/D/E=FlushM=1 in cycles 0–2, McBusy=1 in cycles 1–2, all 0 in cycle 3; StallCount=3. With MC_LAT=1 → no stall.
- Multi-cycle plus load-use in the same cycle: only StallE/FlushM style (FlushE=0) until release, then lwstall is asserted.
- Branch in D (BR_IN_D=1): BranchD=1, RegWriteE=1, WriteRegE=3, RsD=3 → StallF=StallD=FlushE=1. Next cycle WriteRegM=3, RegWriteM=1 → ForwardAD=1, no stall. PCSrcD=1 → FlushD=1.
- BR_IN_D=0 and reset:
  - PCSrcE=1 → FlushD=FlushE=1, ForwardAD=0.
  - Reset in BUSY with MC_LAT=8 → McBusy=0 and counters 0 next cycle.
  - CNT_W=2 with 5 stall cycles → StallCount holds 3.
